// File: rtl/nn_pkg.sv
// ----------------------------------------------------------------------------
// nn_pkg
// Shared types and helpers for the neural-network datapath blocks.
//   act_mode_e   : activation selector (ReLU / hard sigmoid / identity)
//   state_e      : dense layer engine sequencer states
//   ONE          : Q-format 1.0 for the default 8 fractional bits
//   q_one()      : Q-format 1.0 for an arbitrary fractional width
//   clog2_min1() : $clog2 that never returns 0 (for index/port widths)
//   sat_to_width(): clamp a signed value to the range of a w-bit signed word
// ----------------------------------------------------------------------------
package nn_pkg;

    typedef enum logic [1:0] {
        ACT_RELU  = 2'd0,
        ACT_HSIG  = 2'd1,
        ACT_IDENT = 2'd2
    } act_mode_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_BIAS = 3'd1,
        S_MAC  = 3'd2,
        S_ACT  = 3'd3,
        S_DONE = 3'd4,
        S_UPD  = 3'd5
    } state_e;

    localparam int FRAC_W_DEFAULT = 8;
    localparam int ONE            = 1 << FRAC_W_DEFAULT;

    function automatic int q_one(input int frac_w);
        return 1 << frac_w;
    endfunction

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Callers truncate the result back to w bits; the wide return keeps the
    // function usable for any operand width up to 64.
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                        input int w);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (w - 1));
        if (v > max_v)
            return max_v;
        else if (v < min_v)
            return min_v;
        else
            return v;
    endfunction

endpackage

// File: rtl/nn_activation.sv
// ----------------------------------------------------------------------------
// nn_activation
// Combinational saturate-then-activate stage, shared by all layer types.
//   v_in  : signed IN_W-bit value already aligned to Q(DATA_W-FRAC_W).FRAC_W
//   y_out : signed DATA_W-bit activation
// ACT_MODE 0 = ReLU, 1 = hard sigmoid clamp((v>>>2)+0.5, 0, 1.0), 2 = identity.
// ----------------------------------------------------------------------------
module nn_activation
    import nn_pkg::*;
#(
    parameter int ACT_MODE = 0,
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 8,
    parameter int IN_W     = 34
) (
    input  logic signed [IN_W-1:0]   v_in,
    output logic signed [DATA_W-1:0] y_out
);

    localparam logic signed [DATA_W:0] ONE_Q  = (DATA_W+1)'(q_one(FRAC_W));
    localparam logic signed [DATA_W:0] HALF_Q = ONE_Q >>> 1;

    logic signed [DATA_W-1:0] v_sat;
    logic signed [DATA_W:0]   hs;   // one extra bit so the +0.5 cannot wrap

    always_comb begin
        v_sat = DATA_W'(sat_to_width(64'(v_in), DATA_W));
        hs    = (DATA_W+1)'(v_sat >>> 2) + HALF_Q;
        y_out = v_sat;
        case (act_mode_e'(ACT_MODE))
            ACT_RELU: begin
                if (v_sat[DATA_W-1])
                    y_out = '0;
            end
            ACT_HSIG: begin
                if (hs[DATA_W])
                    y_out = '0;
                else if (hs > ONE_Q)
                    y_out = DATA_W'(ONE_Q);
                else
                    y_out = DATA_W'(hs);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dense_layer_engine.sv
// ----------------------------------------------------------------------------
// dense_layer_engine
// Time-multiplexed fully-connected layer: N_OUT neurons of N_IN inputs, one
// multiply-accumulate per cycle, signed Q(DATA_W-FRAC_W).FRAC_W arithmetic.
// Per neuron: BIAS (1 cycle) -> MAC (N_IN cycles) -> ACT (1 cycle), so a
// result appears N_OUT*(N_IN+2) cycles after the input is accepted.
//
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   in_valid/in_ready     : input vector handshake (ready only when idle)
//   in_data               : packed inputs, x[0] in the LSBs
//   out_valid/out_ready   : result handshake, results held until accepted
//   out_data, out_argmax  : packed activations (y[0] in LSBs), index of max
//   w_wr_en/addr/data     : weight write port, addr = o*(N_IN+1)+i, i==N_IN
//                           is the bias; honoured only while idle
//   upd_valid/ready/delta : SGD update request with per-neuron deltas
//   upd_done              : one-cycle pulse when an update finishes
//   busy                  : high while computing or updating
//
// Build option: define DENSE_LAYER_TRAIN_EN to include the SGD update
// sequencer; without it the update port is inert (ready/done tied low).
// ----------------------------------------------------------------------------
module dense_layer_engine
    import nn_pkg::*;
#(
    parameter int N_IN     = 2,
    parameter int N_OUT    = 3,
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 8,
    parameter int ACT_MODE = 0,
    parameter int LR_SHIFT = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [N_IN*DATA_W-1:0]                in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [N_OUT*DATA_W-1:0]               out_data,
    output logic [clog2_min1(N_OUT)-1:0]          out_argmax,
    input  logic                                  w_wr_en,
    input  logic [clog2_min1(N_OUT*(N_IN+1))-1:0] w_wr_addr,
    input  logic [DATA_W-1:0]                     w_wr_data,
    input  logic                                  upd_valid,
    output logic                                  upd_ready,
    input  logic [N_OUT*DATA_W-1:0]               upd_delta,
    output logic                                  upd_done,
    output logic                                  busy
);

    localparam int N_W   = N_OUT * (N_IN + 1);
    localparam int OW    = clog2_min1(N_OUT);
    localparam int IW    = clog2_min1(N_IN + 1);
    localparam int P_W   = 2 * DATA_W;
    localparam int ACC_W = 2 * DATA_W + $clog2(N_IN + 1);

    state_e                   state;
    logic [OW-1:0]            o_idx;
    logic [IW-1:0]            i_idx;
    logic signed [DATA_W-1:0] w_mem [N_W];
    logic signed [DATA_W-1:0] x_lat [N_IN];
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [DATA_W-1:0] best_y;
    logic signed [DATA_W-1:0] y_act;
    logic signed [DATA_W-1:0] w_rd;
    logic signed [DATA_W-1:0] x_sel;
    logic signed [P_W-1:0]    prod;
    int                       rd_addr;

    // ------------------------------------------------------------------
    // Operand selection: weight/bias for the current step and its input.
    // ------------------------------------------------------------------
    always_comb begin
        rd_addr = int'(o_idx) * (N_IN + 1) + ((state == S_BIAS) ? N_IN : int'(i_idx));
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_rd = '0;
        for (int k = 0; k < N_W; k++)
            if (rd_addr == k)
                w_rd = w_mem[k];
        x_sel = '0;
        for (int k = 0; k < N_IN; k++)
            if (int'(i_idx) == k)
                x_sel = x_lat[k];
    end

    assign prod  = P_W'(w_rd) * P_W'(x_sel);
    assign acc_q = acc >>> FRAC_W;

    nn_activation #(
        .ACT_MODE (ACT_MODE),
        .DATA_W   (DATA_W),
        .FRAC_W   (FRAC_W),
        .IN_W     (ACC_W)
    ) u_act (
        .v_in  (acc_q),
        .y_out (y_act)
    );

`ifdef DENSE_LAYER_TRAIN_EN
    logic signed [DATA_W-1:0] delta_lat [N_OUT];
    logic signed [DATA_W-1:0] d_sel;
    logic signed [DATA_W-1:0] step;
    logic signed [DATA_W-1:0] w_upd;
    logic signed [P_W-1:0]    upd_prod;
    logic signed [P_W-1:0]    upd_scaled;
    logic signed [DATA_W:0]   w_diff;

    // Gradient step for the weight at rd_addr; i_idx==N_IN selects the bias,
    // whose gradient is the delta itself.
    always_comb begin
        d_sel = '0;
        for (int k = 0; k < N_OUT; k++)
            if (int'(o_idx) == k)
                d_sel = delta_lat[k];
        upd_prod   = P_W'(d_sel) * P_W'(x_sel);
        upd_scaled = (upd_prod >>> FRAC_W) >>> LR_SHIFT;
        if (int'(i_idx) == N_IN)
            step = d_sel >>> LR_SHIFT;
        else
            step = DATA_W'(sat_to_width(64'(upd_scaled), DATA_W));
        w_diff = (DATA_W+1)'(w_rd) - (DATA_W+1)'(step);
        w_upd  = DATA_W'(sat_to_width(64'(w_diff), DATA_W));
    end
`else
    // Update port is inert in this build; the reductions keep the unused
    // inputs and parameter visibly accounted for.
    logic unused_upd;
    localparam int unused_lr_shift = LR_SHIFT;
    assign unused_upd = ^{upd_valid, upd_delta};
    assign upd_ready  = 1'b0;
    assign upd_done   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Weight store. Writes from the port land only while idle, so a write
    // coinciding with an accepted input is visible to that inference.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: weights are flops, not RAM, because reset must return
            // every weight to zero; a RAM macro could not be cleared here.
            for (int k = 0; k < N_W; k++)
                w_mem[k] <= '0;
        end else begin
            for (int k = 0; k < N_W; k++) begin
                if (state == S_IDLE && w_wr_en && int'(w_wr_addr) == k)
                    w_mem[k] <= w_wr_data;
`ifdef DENSE_LAYER_TRAIN_EN
                if (state == S_UPD && rd_addr == k)
                    w_mem[k] <= w_upd;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer with registered handshake/status outputs.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            o_idx      <= '0;
            i_idx      <= '0;
            acc        <= '0;
            best_y     <= '0;
            out_data   <= '0;
            out_argmax <= '0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            for (int k = 0; k < N_IN; k++)
                x_lat[k] <= '0;
`ifdef DENSE_LAYER_TRAIN_EN
            upd_ready  <= 1'b0;
            upd_done   <= 1'b0;
            for (int k = 0; k < N_OUT; k++)
                delta_lat[k] <= '0;
`endif
        end else begin
`ifdef DENSE_LAYER_TRAIN_EN
            upd_done <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
`ifdef DENSE_LAYER_TRAIN_EN
                    upd_ready <= 1'b1;
`endif
                    // Inference takes priority over a simultaneous update.
                    if (in_valid && in_ready) begin
                        for (int k = 0; k < N_IN; k++)
                            x_lat[k] <= in_data[k*DATA_W +: DATA_W];
                        state    <= S_BIAS;
                        o_idx    <= '0;
                        i_idx    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
`ifdef DENSE_LAYER_TRAIN_EN
                        upd_ready <= 1'b0;
                    end else if (upd_valid && upd_ready) begin
                        for (int k = 0; k < N_OUT; k++)
                            delta_lat[k] <= upd_delta[k*DATA_W +: DATA_W];
                        state     <= S_UPD;
                        o_idx     <= '0;
                        i_idx     <= '0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        upd_ready <= 1'b0;
`endif
                    end
                end
                S_BIAS: begin
                    acc   <= ACC_W'(w_rd) <<< FRAC_W;
                    i_idx <= '0;
                    state <= S_MAC;
                end
                S_MAC: begin
                    acc <= acc + ACC_W'(prod);
                    if (int'(i_idx) == N_IN - 1)
                        state <= S_ACT;
                    else
                        i_idx <= i_idx + 1'b1;
                end
                S_ACT: begin
                    for (int k = 0; k < N_OUT; k++)
                        if (int'(o_idx) == k)
                            out_data[k*DATA_W +: DATA_W] <= y_act;
                    // Strict compare keeps the lowest index on ties.
                    if (o_idx == '0 || y_act > best_y) begin
                        best_y     <= y_act;
                        out_argmax <= o_idx;
                    end
                    if (int'(o_idx) == N_OUT - 1) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        o_idx <= o_idx + 1'b1;
                        state <= S_BIAS;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
`ifdef DENSE_LAYER_TRAIN_EN
                S_UPD: begin
                    if (int'(i_idx) == N_IN) begin
                        i_idx <= '0;
                        if (int'(o_idx) == N_OUT - 1) begin
                            state     <= S_IDLE;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                            upd_ready <= 1'b1;
                            upd_done  <= 1'b1;
                        end else begin
                            o_idx <= o_idx + 1'b1;
                        end
                    end else begin
                        i_idx <= i_idx + 1'b1;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_layer_engine.sv
// ----------------------------------------------------------------------------
// tb_dense_layer_engine
// Directed, self-checking bench. Three engine instances share all inputs and
// differ only in ACT_MODE (0 ReLU, 1 hard sigmoid, 2 identity), so one
// stimulus sequence exercises every activation. Expected values are
// hand-computed Q8.8 constants.
// ----------------------------------------------------------------------------
module tb_dense_layer_engine;

    localparam int RELU  = 0;
    localparam int HSIG  = 1;
    localparam int IDENT = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        w_wr_en = 1'b0;
    logic        upd_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic [3:0]  w_wr_addr = '0;
    logic [15:0] w_wr_data = '0;
    logic [47:0] upd_delta = '0;

    logic        in_ready_m  [3];
    logic        out_valid_m [3];
    logic [47:0] out_data_m  [3];
    logic [1:0]  argmax_m    [3];
    logic        upd_ready_m [3];
    logic        upd_done_m  [3];
    logic        busy_m      [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dense_layer_engine #(
            .N_IN(2), .N_OUT(3), .DATA_W(16), .FRAC_W(8), .ACT_MODE(g), .LR_SHIFT(2)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .in_valid   (in_valid),
            .in_ready   (in_ready_m[g]),
            .in_data    (in_data),
            .out_valid  (out_valid_m[g]),
            .out_ready  (out_ready),
            .out_data   (out_data_m[g]),
            .out_argmax (argmax_m[g]),
            .w_wr_en    (w_wr_en),
            .w_wr_addr  (w_wr_addr),
            .w_wr_data  (w_wr_data),
            .upd_valid  (upd_valid),
            .upd_ready  (upd_ready_m[g]),
            .upd_delta  (upd_delta),
            .upd_done   (upd_done_m[g]),
            .busy       (busy_m[g])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic write_w(input int addr, input logic [15:0] data);
        @(negedge clk);
        w_wr_en   = 1'b1;
        w_wr_addr = 4'(addr);
        w_wr_data = data;
        @(posedge clk);
        #1 w_wr_en = 1'b0;
    endtask

    task automatic load_all(input logic [15:0] w, input logic [15:0] b);
        for (int o = 0; o < 3; o++)
            for (int i = 0; i < 3; i++)
                write_w(o * 3 + i, (i == 2) ? b : w);
    endtask

    // Present one vector; in_data is scrambled right after the accepting edge
    // to show the engine works from its latched copy.
    task automatic accept(input string tag, input logic [15:0] x0, input logic [15:0] x1);
        @(negedge clk);
        check({tag, "_in_ready"}, in_ready_m[RELU], 1);
        in_valid = 1'b1;
        in_data  = {x1, x0};
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
    endtask

    // Called #1 after the accepting edge; out_valid must rise after edge 12.
    task automatic wait_result(input string tag);
        int n;
        n = 0;
        while (out_valid_m[RELU] !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, n, 12);
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_idle_in_ready"}, in_ready_m[RELU], 1);
        check({tag, "_idle_out_valid"}, out_valid_m[RELU], 0);
    endtask

    task automatic check_out(input string tag, input int m,
                             input logic [47:0] exp_y, input logic [1:0] exp_arg);
        check({tag, "_y"}, out_data_m[m], exp_y);
        check({tag, "_argmax"}, argmax_m[m], exp_arg);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("rst_out_valid", out_valid_m[RELU], 0);
        check("rst_in_ready", in_ready_m[RELU], 1);
        check("rst_busy", busy_m[RELU], 0);
        check("rst_out_data", out_data_m[RELU], 0);
        check("rst_argmax", argmax_m[RELU], 0);
        check("rst_upd_ready", upd_ready_m[RELU], 0);
        check("rst_upd_done", upd_done_m[RELU], 0);
        @(negedge clk);
        reset = 1'b1;

        // Unit weights, zero bias, x=(1.0,1.0): every neuron 2.0
        load_all(16'h0100, 16'h0000);
        accept("t1", 16'h0100, 16'h0100);
        wait_result("t1");
        check_out("t1_relu", RELU, 48'h0200_0200_0200, 2'd0);
        check_out("t1_ident", IDENT, 48'h0200_0200_0200, 2'd0);
        check_out("t1_hsig", HSIG, 48'h0100_0100_0100, 2'd0);
        release_result("t1");

        // Bias write in the same cycle as the accept is used by that inference
        @(negedge clk);
        w_wr_en   = 1'b1;
        w_wr_addr = 4'd8;
        w_wr_data = 16'h0100;
        in_valid  = 1'b1;
        in_data   = {16'h0100, 16'h0100};
        @(posedge clk);
        #1;
        w_wr_en  = 1'b0;
        in_valid = 1'b0;
        wait_result("wr_acc");
        check_out("wr_acc_relu", RELU, 48'h0300_0200_0200, 2'd2);
        release_result("wr_acc");

        // Weights -1.0, bias 0.5: pre-activation -1.5
        load_all(16'hFF00, 16'h0080);
        accept("t2", 16'h0100, 16'h0100);
        wait_result("t2");
        check_out("t2_relu", RELU, 48'h0000_0000_0000, 2'd0);
        check_out("t2_ident", IDENT, 48'hFE80_FE80_FE80, 2'd0);
        check("t2_hsig_y", out_data_m[HSIG], 48'h0020_0020_0020);
        release_result("t2");

        // Positive saturation
        load_all(16'h7FFF, 16'h0000);
        accept("t3", 16'h7FFF, 16'h7FFF);
        wait_result("t3");
        check("t3_ident_y", out_data_m[IDENT], 48'h7FFF_7FFF_7FFF);
        check("t3_relu_y", out_data_m[RELU], 48'h7FFF_7FFF_7FFF);
        check("t3_hsig_y", out_data_m[HSIG], 48'h0100_0100_0100);
        release_result("t3");

        // Zero accumulator: hard sigmoid gives 0.5
        load_all(16'h0000, 16'h0000);
        accept("t4", 16'h1234, 16'h4321);
        wait_result("t4");
        check_out("t4_hsig", HSIG, 48'h0080_0080_0080, 2'd0);
        check_out("t4_relu", RELU, 48'h0000_0000_0000, 2'd0);
        release_result("t4");

        // Argmax tie between neurons 1 and 2 goes to 1
        write_w(2, 16'h0010);
        write_w(5, 16'h0030);
        write_w(8, 16'h0030);
        accept("t5", 16'h0100, 16'h0100);
        wait_result("t5");
        check_out("t5_relu", RELU, 48'h0030_0030_0010, 2'd1);
        check_out("t5_ident", IDENT, 48'h0030_0030_0010, 2'd1);
        release_result("t5");

        // All-negative outputs: argmax is the least negative
        write_w(2, 16'hFF00);
        write_w(5, 16'hFFE0);
        write_w(8, 16'hFF80);
        accept("t6", 16'h0100, 16'h0100);
        wait_result("t6");
        check_out("t6_ident", IDENT, 48'hFF80_FFE0_FF00, 2'd1);
        check_out("t6_relu", RELU, 48'h0000_0000_0000, 2'd0);
        check_out("t6_hsig", HSIG, 48'h0060_0078_0040, 2'd1);
        release_result("t6");

        // Back-pressure: results held, writes ignored while not idle
        load_all(16'h0100, 16'h0000);
        accept("hold", 16'h0100, 16'h0100);
        wait_result("hold");
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            w_wr_en   = 1'b1;
            w_wr_addr = 4'(c % 9);
            w_wr_data = 16'h7FFF;
            @(posedge clk);
            #1;
            check("hold_y", out_data_m[RELU], 48'h0200_0200_0200);
            check("hold_in_ready", in_ready_m[RELU], 0);
            check("hold_out_valid", out_valid_m[RELU], 1);
        end
        w_wr_en = 1'b0;
        release_result("hold");
        accept("hold2", 16'h0100, 16'h0100);
        wait_result("hold2");
        check_out("hold2_relu", RELU, 48'h0200_0200_0200, 2'd0);
        release_result("hold2");

        // Reset during the MAC phase of neuron 1 (5 edges after accept)
        accept("rmid", 16'h0100, 16'h0100);
        repeat (5) @(posedge clk);
        #1;
        check("rmid_busy_before", busy_m[RELU], 1);
        reset = 1'b0;
        #1;
        check("rmid_out_valid", out_valid_m[RELU], 0);
        check("rmid_busy", busy_m[RELU], 0);
        check("rmid_in_ready", in_ready_m[RELU], 1);
        check("rmid_out_data", out_data_m[RELU], 0);
        @(negedge clk);
        reset = 1'b1;
        accept("rfresh", 16'h0100, 16'h0100);
        wait_result("rfresh");
        check_out("rfresh_relu", RELU, 48'h0000_0000_0000, 2'd0);
        check("rfresh_hsig_y", out_data_m[HSIG], 48'h0080_0080_0080);
        release_result("rfresh");
        load_all(16'h0100, 16'h0000);
        accept("rload", 16'h0100, 16'h0100);
        wait_result("rload");
        check_out("rload_relu", RELU, 48'h0200_0200_0200, 2'd0);
        release_result("rload");

`ifdef DENSE_LAYER_TRAIN_EN
        // SGD step with the inputs latched by the last inference
        begin
            int n;
            @(negedge clk);
            check("upd_ready_idle", upd_ready_m[RELU], 1);
            upd_valid = 1'b1;
            upd_delta = {3{16'h0100}};
            @(posedge clk);
            #1;
            upd_valid = 1'b0;
            n = 0;
            while (upd_done_m[RELU] !== 1'b1 && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("upd_latency", n, 9);
            check("upd_idle_busy", busy_m[RELU], 0);
            @(posedge clk);
            #1;
            check("upd_done_pulse", upd_done_m[RELU], 0);
            accept("post_upd", 16'h0100, 16'h0100);
            wait_result("post_upd");
            check_out("post_upd_relu", RELU, 48'h0140_0140_0140, 2'd0);
            release_result("post_upd");
        end
`else
        // Update port is inert without the training build
        @(negedge clk);
        upd_valid = 1'b1;
        upd_delta = {3{16'h0100}};
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        check("noupd_busy", busy_m[RELU], 0);
        check("noupd_ready", upd_ready_m[RELU], 0);
        check("noupd_in_ready", in_ready_m[RELU], 1);
        accept("noupd", 16'h0100, 16'h0100);
        wait_result("noupd");
        check_out("noupd_relu", RELU, 48'h0200_0200_0200, 2'd0);
        release_result("noupd");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dense_layer_engine.md
Name: dense_layer_engine

Overview:
- Parametrised, time-multiplexed fully-connected layer: N_IN inputs, N_OUT neurons, signed fixed-point, selectable activation. One MAC per cycle.
- Successor to the fixed 2-3-1 XOR network. Instances chain into multi-layer networks, and it reports the argmax class as the prediction.
- Weights are loaded through a write port. An optional SGD update mode is compiled in by macro.

Parameters:
- N_IN, 2, inputs per neuron (>=1)
- N_OUT, 3, neurons in layer (>=1)
- DATA_W, 16, signed data/weight width
- FRAC_W, 8, fractional bits (Q(DATA_W-FRAC_W).FRAC_W)
- ACT_MODE, 0, 0=ReLU, 1=hard sigmoid, 2=identity
- LR_SHIFT, 2, learning rate = 2^-LR_SHIFT (train mode only)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  input vector valid
- in_ready  out  1  engine idle and able to accept
- in_data  in  N_IN*DATA_W  packed inputs, x[0] in LSBs
- out_valid  out  1  results valid, held until accepted
- out_ready  in  1  consumer accepts results
- out_data  out  N_OUT*DATA_W  packed activations, y[0] in LSBs
- out_argmax  out  $clog2(N_OUT) (min 1)  index of largest y; ties go to lowest index
- w_wr_en  in  1  weight write strobe
- w_wr_addr  in  $clog2(N_OUT*(N_IN+1))  address o*(N_IN+1)+i; i==N_IN is the bias
- w_wr_data  in  DATA_W  weight value
- upd_valid  in  1  update request (train mode)
- upd_ready  out  1  update accepted
- upd_delta  in  N_OUT*DATA_W  packed per-neuron error deltas
- upd_done  out  1  one-cycle pulse when the update completes
- busy  out  1  high in any state except IDLE/DONE

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; all weights, latched inputs, accumulator, out_data and out_argmax = 0; out_valid=0, upd_done=0, in_ready=1, upd_ready=0.
- States and transitions:
  - IDLE -> BIAS on in_valid&in_ready.
  - BIAS: acc = sign-extended bias <<< FRAC_W.
  - MAC: N_IN cycles, acc += w[o][i]*x[i] at full precision. ACC_W = 2*DATA_W + $clog2(N_IN+1).
  - ACT: y[o] = act(sat(acc >>> FRAC_W)), using truncating arithmetic shift; argmax updated. Then next neuron -> BIAS, or DONE after the last neuron.
  - DONE: out_valid=1. On out_ready -> IDLE.
- Latency: out_valid rises exactly N_OUT*(N_IN+2) cycles after the accepting edge (12 cycles for defaults).
- in_ready=1 only in IDLE. in_data is latched on accept; later changes are ignored.
- out_data and out_argmax are stable while out_valid=1 and out_ready=0. in_ready stays 0 in that condition.
- Saturation: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Activations:
  - ReLU: negative -> 0.
  - Hard sigmoid: clamp((v>>>2) + 0.5, 0, 1.0).
  - Identity: v.
- Weight writes are honoured only in IDLE and ignored elsewhere. If w_wr_en and in_valid coincide in IDLE, both happen and the inference uses the newly written weight.
- If in_valid and upd_valid coincide in IDLE, inference wins.
- Reset mid-operation aborts the operation immediately. Weights return to 0.

Optional Feature:
- Macro DENSE_LAYER_TRAIN_EN.
- Defined:
  - upd_ready=1 in IDLE. Accepting an update latches upd_delta and enters UPD.
  - UPD runs N_OUT*(N_IN+1) cycles, one weight per cycle, using the inputs latched at the last inference:
    - weights: w -= sat(((delta*x) >>> FRAC_W) >>> LR_SHIFT)
    - bias: w -= delta >>> LR_SHIFT
  - Subtraction saturates. upd_done pulses on the cycle UPD returns to IDLE.
- Undefined: upd_ready and upd_done are tied to 0, upd_valid and upd_delta are ignored, and no UPD logic is present.

Decomposition:
- Package nn_pkg holds:
  - act_mode_e enum
  - engine state enum (IDLE, BIAS, MAC, ACT, DONE, UPD)
  - sat_to_width function
  - Q-format constant ONE = 1<<FRAC_W
- Sub-module nn_activation: combinational saturate plus activation, parametrised by ACT_MODE/DATA_W/FRAC_W. Shared with future layers.

Test Plan:
- Defaults, ReLU. All weights 0x0100, biases 0, x=(0x0100,0x0100) -> out_data all 0x0200, argmax=0 (tie), out_valid exactly 12 cycles after accept.
- ReLU, weights 0xFF00 (-1.0), bias 0x0080 -> all y=0x0000. Same with ACT_MODE=2 -> y=0xFE80.
- ACT_MODE=2, weights 0x7FFF, x=0x7FFF -> y=0x7FFF (saturated). ACT_MODE=1, acc=0 -> y=0x0080; acc >= 2.0 -> y=0x0100.
- Hold out_ready=0 for 20 cycles -> out_data stable, in_ready=0, w_wr_en writes ignored. Pulse out_ready -> IDLE the next cycle.
- Assert reset low during MAC of neuron 1 -> out_valid=0, busy=0, weights=0 immediately. A new inference after release behaves like a fresh run.
- With DENSE_LAYER_TRAIN_EN, LR_SHIFT=2, w=0x0100, x=0x0100, bias=0, delta=0x0100 -> w=0x00C0, bias=0xFFC0. upd_done pulses 9 cycles after accept.
